// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// control constants and stall-vector bit positions.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP     = 32'h0;
    localparam logic        STOP    = 1'b1;
    localparam logic        NO_STOP = 1'b0;
    localparam logic        ENABLE  = 1'b1;
    localparam logic        DISABLE = 1'b0;

    localparam int STALL_W  = 6;
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;

endpackage

// File: rtl/if_fetch_id_reg.sv
// IF/ID pipeline register: bubbles on flush or when IF stalls alone,
// holds when IF and ID both stall, otherwise loads the delivered word.
module if_id_reg
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        load_valid,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic        id_valid_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    always_comb begin
        // NOTE: hold is the default so every path assigns all _d signals; no latch is inferred.
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush || (stall_if && !stall_id)) begin
            pc_d    = NOP;
            inst_d  = NOP;
            valid_d = 1'b0;
        end else if (stall_if) begin
            // both IF and ID stalled: keep the current contents
        end else if (load_valid) begin
            pc_d    = load_pc;
            inst_d  = load_inst;
            valid_d = 1'b1;
        end else begin
            pc_d    = NOP;
            inst_d  = NOP;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= NOP;
            inst_q  <= NOP;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign id_pc_o    = pc_q;
    assign id_inst_o  = inst_q;
    assign id_valid_o = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: request/ack handshake FSM with a one-entry
// hold buffer for words fetched while IF is stalled.
module if_fetch
    import if_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [31:0]        pc_i,
    output logic               imem_req_o,
    output logic [31:0]        imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [31:0]        imem_data_i,
    output logic [31:0]        id_pc_o,
    output logic [31:0]        id_inst_o,
    output logic               id_valid_o,
    output logic               stallreq_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  hold_inst_q, hold_inst_d;

    logic         load_valid;
    logic [31:0]  load_pc;
    logic [31:0]  load_inst;
    logic         stall_if;
    logic         unused_stall;

    assign stall_if     = stall[STALL_IF];
    assign unused_stall = ^{stall[STALL_W-1:STALL_ID+1], stall[STALL_PC]};

    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        imem_req_o  = DISABLE;
        imem_addr_o = NOP;
        stallreq_o  = NO_STOP;
        load_valid  = 1'b0;
        load_pc     = NOP;
        load_inst   = NOP;

        unique case (state_q)
            S_IDLE: state_d = S_RUN;
            S_RUN: begin
                imem_req_o  = ENABLE;
                imem_addr_o = pc_i;
                req_addr_d  = pc_i;
                if (imem_ack_i) begin
                    if (flush) begin
                        // word belongs to the flushed path; drop it
                    end else if (stall_if) begin
                        hold_pc_d   = pc_i;
                        hold_inst_d = imem_data_i;
                        state_d     = S_HOLD;
                    end else begin
                        load_valid = 1'b1;
                        load_pc    = pc_i;
                        load_inst  = imem_data_i;
                    end
                end else begin
                    stallreq_o = STOP;
                    if (flush) state_d = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_RUN;
                end else if (!stall_if) begin
                    load_valid = 1'b1;
                    load_pc    = hold_pc_q;
                    load_inst  = hold_inst_q;
                    state_d    = S_RUN;
                end
            end
            S_DISCARD: begin
                // pc_i may already point at the redirect target; keep the old address stable
                imem_req_o  = ENABLE;
                imem_addr_o = req_addr_q;
                stallreq_o  = STOP;
                if (imem_ack_i) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so all flops update from pre-edge values.
        if (!rst) begin
            state_q     <= S_IDLE;
            req_addr_q  <= NOP;
            hold_pc_q   <= NOP;
            hold_inst_q <= NOP;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .stall_if   (stall_if),
        .stall_id   (stall[STALL_ID]),
        .load_valid (load_valid),
        .load_pc    (load_pc),
        .load_inst  (load_inst),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: vector table with an IF/ID scoreboard,
// plus zero-wait streaming and asynchronous-reset sequences.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        stallreq_o;

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .pc_i        (pc_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .id_pc_o     (id_pc_o),
        .id_inst_o   (id_inst_o),
        .id_valid_o  (id_valid_o),
        .stallreq_o  (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_sreq;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_val;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
    } id_t;

    localparam int NV = 22;
    vec_t vecs[NV];
    id_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] st, input logic fl, input logic [31:0] pc,
                                input logic ack, input logic [31:0] data, input logic e_req,
                                input logic [31:0] e_addr, input logic e_sreq,
                                input logic [31:0] e_pc, input logic [31:0] e_inst,
                                input logic e_val);
        vec_t v;
        v.stall = st;  v.flush = fl;  v.pc = pc;  v.ack = ack;  v.data = data;
        v.e_req = e_req;  v.e_addr = e_addr;  v.e_sreq = e_sreq;
        v.e_pc = e_pc;  v.e_inst = e_inst;  v.e_val = e_val;
        return v;
    endfunction

    task automatic push_id(input logic [31:0] pc, input logic [31:0] inst, input logic valid);
        id_t e;
        e.pc = pc;  e.inst = inst;  e.valid = valid;
        sb.push_back(e);
    endtask

    task automatic check_id(input string tag);
        id_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got pc %h", tag, id_pc_o);
        end else begin
            e = sb.pop_front();
            check({tag, " id_pc"}, id_pc_o, e.pc);
            check({tag, " id_inst"}, id_inst_o, e.inst);
            check({tag, " id_valid"}, {31'b0, id_valid_o}, {31'b0, e.valid});
        end
    endtask

    // Holds reset for two edges, checks the reset state, releases just after a rising edge.
    task automatic do_reset(input logic [31:0] pc, input logic ack);
        rst = 1'b0;
        stall = '0;  flush = 1'b0;  pc_i = pc;  imem_ack_i = ack;  imem_data_i = '0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst req", {31'b0, imem_req_o}, 32'd0);
        check("rst addr", imem_addr_o, 32'd0);
        check("rst sreq", {31'b0, stallreq_o}, 32'd0);
        check("rst valid", {31'b0, id_valid_o}, 32'd0);
        check("rst id_pc", id_pc_o, 32'd0);
        check("rst id_inst", id_inst_o, 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        //            stall  fl pc          ack data          req addr        sreq id_pc       id_inst       val
        vecs[0]  = mk(6'h00, 0, 32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0,        0);
        vecs[1]  = mk(6'h00, 0, 32'h100, 0, 32'h0,        1, 32'h100, 1, 32'h0,   32'h0,        0);
        vecs[2]  = mk(6'h00, 0, 32'h100, 0, 32'h0,        1, 32'h100, 1, 32'h0,   32'h0,        0);
        vecs[3]  = mk(6'h00, 0, 32'h100, 0, 32'h0,        1, 32'h100, 1, 32'h0,   32'h0,        0);
        vecs[4]  = mk(6'h00, 0, 32'h100, 1, 32'h24020005, 1, 32'h100, 0, 32'h100, 32'h24020005, 1);
        vecs[5]  = mk(6'h03, 0, 32'h104, 1, 32'h11111111, 1, 32'h104, 0, 32'h0,   32'h0,        0);
        vecs[6]  = mk(6'h03, 0, 32'h104, 1, 32'hBAD00006, 0, 32'h0,   0, 32'h0,   32'h0,        0);
        vecs[7]  = mk(6'h00, 0, 32'h104, 0, 32'h0,        0, 32'h0,   0, 32'h104, 32'h11111111, 1);
        vecs[8]  = mk(6'h00, 0, 32'h108, 1, 32'h22222222, 1, 32'h108, 0, 32'h108, 32'h22222222, 1);
        vecs[9]  = mk(6'h07, 0, 32'h10C, 1, 32'h33333333, 1, 32'h10C, 0, 32'h108, 32'h22222222, 1);
        vecs[10] = mk(6'h07, 0, 32'h10C, 0, 32'h0,        0, 32'h0,   0, 32'h108, 32'h22222222, 1);
        vecs[11] = mk(6'h00, 0, 32'h10C, 0, 32'h0,        0, 32'h0,   0, 32'h10C, 32'h33333333, 1);
        vecs[12] = mk(6'h00, 0, 32'h200, 0, 32'h0,        1, 32'h200, 1, 32'h0,   32'h0,        0);
        vecs[13] = mk(6'h00, 1, 32'h200, 0, 32'h0,        1, 32'h200, 1, 32'h0,   32'h0,        0);
        vecs[14] = mk(6'h00, 0, 32'h080, 0, 32'h0,        1, 32'h200, 1, 32'h0,   32'h0,        0);
        vecs[15] = mk(6'h00, 0, 32'h080, 1, 32'hDEAD0200, 1, 32'h200, 1, 32'h0,   32'h0,        0);
        vecs[16] = mk(6'h00, 0, 32'h080, 1, 32'h44444444, 1, 32'h080, 0, 32'h080, 32'h44444444, 1);
        vecs[17] = mk(6'h00, 1, 32'h084, 1, 32'h55555555, 1, 32'h084, 0, 32'h0,   32'h0,        0);
        vecs[18] = mk(6'h00, 0, 32'h088, 1, 32'h66666666, 1, 32'h088, 0, 32'h088, 32'h66666666, 1);
        vecs[19] = mk(6'h03, 0, 32'h08C, 1, 32'h77777777, 1, 32'h08C, 0, 32'h0,   32'h0,        0);
        vecs[20] = mk(6'h00, 1, 32'h08C, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0,        0);
        vecs[21] = mk(6'h00, 0, 32'h090, 1, 32'h88888888, 1, 32'h090, 0, 32'h090, 32'h88888888, 1);

        // Vector table: handshake waits, HOLD, flush/DISCARD corners.
        do_reset(32'h100, 1'b0);
        for (int i = 0; i < NV; i++) begin
            stall = vecs[i].stall;  flush = vecs[i].flush;  pc_i = vecs[i].pc;
            imem_ack_i = vecs[i].ack;  imem_data_i = vecs[i].data;
            push_id(vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_val);
            @(negedge clk);
            check($sformatf("v%0d req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].e_req});
            if (vecs[i].e_req)
                check($sformatf("v%0d addr", i), imem_addr_o, vecs[i].e_addr);
            check($sformatf("v%0d sreq", i), {31'b0, stallreq_o}, {31'b0, vecs[i].e_sreq});
            @(posedge clk);
            #1;
            check_id($sformatf("v%0d", i));
        end

        // Zero-wait memory: one IDLE cycle, then one instruction per cycle.
        do_reset(32'h0, 1'b1);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            imem_data_i = pc_i ^ 32'hA5A50000;
            if (cyc == 1) push_id(32'h0, 32'h0, 1'b0);
            else          push_id(pc_i, pc_i ^ 32'hA5A50000, 1'b1);
            @(negedge clk);
            check($sformatf("s%0d req", cyc), {31'b0, imem_req_o}, {31'b0, cyc != 1});
            check($sformatf("s%0d sreq", cyc), {31'b0, stallreq_o}, 32'd0);
            if (cyc != 1) check($sformatf("s%0d addr", cyc), imem_addr_o, pc_i);
            @(posedge clk);
            #1;
            check_id($sformatf("s%0d", cyc));
            if (cyc != 1) pc_i = pc_i + 32'd4;
        end

        // Reset asserted mid-transaction drops everything before the next edge.
        imem_ack_i = 1'b0;
        @(negedge clk);
        check("r pre req", {31'b0, imem_req_o}, 32'd1);
        check("r pre sreq", {31'b0, stallreq_o}, 32'd1);
        #1 rst = 1'b0;
        #1;
        check("r async req", {31'b0, imem_req_o}, 32'd0);
        check("r async sreq", {31'b0, stallreq_o}, 32'd0);
        check("r async valid", {31'b0, id_valid_o}, 32'd0);
        check("r async id_pc", id_pc_o, 32'd0);
        imem_ack_i = 1'b1;
        imem_data_i = 32'hCAFEF00D;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        push_id(32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("r idle req", {31'b0, imem_req_o}, 32'd0);
        @(posedge clk);
        #1;
        check_id("r idle");
        push_id(pc_i, 32'hCAFEF00D, 1'b1);
        @(posedge clk);
        #1;
        check_id("r first");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
